plab5_mcore_mem_acc_ndom: RTL and testbench
===========================================

Name: plab5_mcore_mem_acc_ndom

Overview:
Parametrised successor of the per-bank memory access-control gate. It sits between one network port and one single-port test memory, and serves N totally ordered security domains instead of two. Each request is checked against the bank's security level. Legal requests are forwarded to memory. Illegal requests are answered locally with a zeroed "deny" response and are never seen by memory. An outstanding-request FIFO returns responses in order, tags each with its requester's domain, and keeps denied responses ordered behind earlier legal ones.

Parameters:
p_opaque_nbits, 8, opaque field width
p_addr_nbits, 32, address width
p_data_nbits, 128, data width; len width c_len_nbits = clog2(p_data_nbits/8)
p_dom_nbits, 2, domain/level width (2^p_dom_nbits levels, 0 = lowest)
p_max_outs, 4, outstanding-request FIFO depth (power of 2, >=2)
p_cnt_nbits, 16, deny-counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mem_sec_level  in  p_dom_nbits  static level of attached bank
net_req_val  in  1  request valid
net_req_rdy  out  1  request ready
net_req_control  in  3+p_opaque_nbits+p_addr_nbits+c_len_nbits  {type,opaque,addr,len}; type 0=read, 1=write
net_req_data  in  p_data_nbits  write data
net_req_domain  in  p_dom_nbits  requester domain
mem_req_val  out  1  forwarded request valid
mem_req_rdy  in  1  memory ready
mem_req_control  out  same as net_req_control  forwarded control
mem_req_data  out  p_data_nbits  forwarded data
mem_resp_val  in  1  memory response valid
mem_resp_rdy  out  1  memory response ready
mem_resp_control  in  3+p_opaque_nbits+c_len_nbits  {type,opaque,len}
mem_resp_data  in  p_data_nbits  read data
net_resp_val  out  1  response valid
net_resp_rdy  in  1  response ready
net_resp_control  out  3+p_opaque_nbits+c_len_nbits  response control
net_resp_data  out  p_data_nbits  response data
net_resp_domain  out  p_dom_nbits  domain of head entry
deny_count  out  p_cnt_nbits  saturating count of denied requests

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Access policy, combinational on net_req_domain (D) and mem_sec_level (M):
  - read allowed iff D >= M (no read-up);
  - write allowed iff D <= M (no write-down);
  - other type codes are always denied.
- Request path, zero latency, no storage:
  - allowed: mem_req_val = net_req_val & allowed & !full; net_req_rdy = mem_req_rdy & !full;
  - denied: mem_req_val = 0; net_req_rdy = !full;
  - mem_req_control and mem_req_data equal the net inputs bit-for-bit;
  - mem_req_data is driven to 0 whenever mem_req_val = 0, so denied data never reaches memory.
- Push: the FIFO pushes {domain, denied, type, opaque, len} on net_req_val & net_req_rdy.
- full: count == p_max_outs. A pop in the same cycle does NOT unblock a push; no bypass.
- Response path, head entry H, valid when count != 0:
  - H.denied = 1: net_resp_val = 1; control = {H.type, H.opaque, 0}; data = 0; mem_resp_rdy = 0.
  - H.denied = 0: net_resp_val = mem_resp_val; control = mem_resp_control; data = mem_resp_data; mem_resp_rdy = net_resp_rdy.
  - Empty FIFO: net_resp_val = 0 and mem_resp_rdy = 0. A stray memory response stalls and is not dropped.
  - net_resp_domain = H.domain when count != 0, else 0.
  - Pop on net_resp_val & net_resp_rdy.
- Latency: a denied request's response is visible no earlier than the cycle after acceptance. That is exactly the next cycle if the FIFO was empty at acceptance.
- Simultaneous push and pop: count is unchanged, pointers advance modulo p_max_outs, and wrap-around is exercised.
- deny_count increments on each accepted denied request and saturates at all-ones.
- Reset, including mid-transaction: count, pointers and deny_count go to 0. Consequently net_resp_val = 0, mem_resp_rdy = 0, net_req_rdy = mem_req_rdy, and net_resp_domain = 0. In-flight memory responses after reset are the harness's concern; the memory is reset on the same signal.

Test Plan:
- M=1, D=2 read addr 0x100 (write 0xCAFE first with D=1) -> mem_req_val same cycle; response data 0xCAFE, net_resp_domain=2; deny_count=0.
- M=1, D=0 read -> mem_req_val stays 0; next cycle net_resp_val=1, type=0, data=0, net_resp_domain=0; deny_count=1.
- M=1, D=3 write 0xBEEF -> denied, mem_req_data=0, memory unchanged (subsequent D=1 read returns old value); deny_count +1.
- Ordering: allowed read D=2 (memory delayed 5 cycles), then denied read D=0 -> denied response emitted only after the D=2 response pops; domains appear in order 2, 0.
- p_max_outs=4, hold net_resp_rdy=0, issue 5 requests -> net_req_rdy=0 after the 4th. Release with back-to-back traffic for 20 cycles -> pointers wrap, no loss or reorder.
- Assert reset with 3 outstanding entries -> next cycle net_resp_val=0, deny_count=0. 300 denied requests with p_cnt_nbits=8 -> deny_count saturates at 255.

Source files
------------

// File: rtl/plab5_mcore_mem_acc_ndom_if.sv
// ---------------------------------------------------------------------------
// plab5_mcore_mem_acc_ndom_if
//
// Bundles every val/rdy channel around the N-domain memory access gate:
//   net_req_*  : request from the network port (control, data, requester domain)
//   mem_req_*  : request forwarded to the single-port test memory
//   mem_resp_* : response coming back from that memory
//   net_resp_* : response returned to the network port (with domain tag)
//
// Modports:
//   slave  : the access gate's view (consumes net_req/mem_resp, drives the rest)
//   master : the surrounding harness's view (network port plus memory)
//
// Control layouts:
//   request  control = {type[2:0], opaque, addr, len}
//   response control = {type[2:0], opaque, len}
// ---------------------------------------------------------------------------
interface plab5_mcore_mem_acc_ndom_if #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 128,
  parameter int p_dom_nbits    = 2
);

  localparam int c_len_nbits  = $clog2(p_data_nbits/8);
  localparam int c_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits;
  localparam int c_resp_nbits = 3 + p_opaque_nbits + c_len_nbits;

  // network request channel
  logic                    net_req_val;
  logic                    net_req_rdy;
  logic [c_req_nbits-1:0]  net_req_control;
  logic [p_data_nbits-1:0] net_req_data;
  logic [p_dom_nbits-1:0]  net_req_domain;

  // forwarded memory request channel
  logic                    mem_req_val;
  logic                    mem_req_rdy;
  logic [c_req_nbits-1:0]  mem_req_control;
  logic [p_data_nbits-1:0] mem_req_data;

  // memory response channel
  logic                    mem_resp_val;
  logic                    mem_resp_rdy;
  logic [c_resp_nbits-1:0] mem_resp_control;
  logic [p_data_nbits-1:0] mem_resp_data;

  // network response channel
  logic                    net_resp_val;
  logic                    net_resp_rdy;
  logic [c_resp_nbits-1:0] net_resp_control;
  logic [p_data_nbits-1:0] net_resp_data;
  logic [p_dom_nbits-1:0]  net_resp_domain;

  modport slave (
    input  net_req_val, net_req_control, net_req_data, net_req_domain,
    output net_req_rdy,
    output mem_req_val, mem_req_control, mem_req_data,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_control, mem_resp_data,
    output mem_resp_rdy,
    output net_resp_val, net_resp_control, net_resp_data, net_resp_domain,
    input  net_resp_rdy
  );

  modport master (
    output net_req_val, net_req_control, net_req_data, net_req_domain,
    input  net_req_rdy,
    input  mem_req_val, mem_req_control, mem_req_data,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_control, mem_resp_data,
    input  mem_resp_rdy,
    input  net_resp_val, net_resp_control, net_resp_data, net_resp_domain,
    output net_resp_rdy
  );

endinterface

// File: rtl/plab5_mcore_mem_acc_ndom.sv
// ---------------------------------------------------------------------------
// plab5_mcore_mem_acc_ndom
//
// Per-bank access-control gate for N totally ordered security domains.
// Each network request is checked against the bank's static level:
//   read  allowed iff requester domain >= bank level (no read-up)
//   write allowed iff requester domain <= bank level (no write-down)
//   any other type code is denied.
// Allowed requests pass straight through to memory. Denied requests never
// reach memory; they are answered locally with a zeroed response. A small
// in-order FIFO remembers every accepted request so responses leave in
// acceptance order, tagged with the requester's domain.
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   mem_sec_level  : static security level of the attached bank
//   bus            : all val/rdy channels (slave modport of the _if)
//   deny_count     : saturating count of accepted denied requests
// ---------------------------------------------------------------------------
module plab5_mcore_mem_acc_ndom #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 128,
  parameter int p_dom_nbits    = 2,
  parameter int p_max_outs     = 4,
  parameter int p_cnt_nbits    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_dom_nbits-1:0]     mem_sec_level,
  plab5_mcore_mem_acc_ndom_if.slave  bus,
  output logic [p_cnt_nbits-1:0]     deny_count
);

  localparam int c_len_nbits   = $clog2(p_data_nbits/8);
  localparam int c_req_nbits   = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits;
  localparam int c_resp_nbits  = 3 + p_opaque_nbits + c_len_nbits;
  localparam int c_ptr_nbits   = $clog2(p_max_outs);
  localparam int c_count_nbits = c_ptr_nbits + 1;

  localparam logic [c_count_nbits-1:0] c_count_zero = {c_count_nbits{1'b0}};
  localparam logic [c_count_nbits-1:0] c_count_one  = c_count_nbits'(1);
  localparam logic [c_count_nbits-1:0] c_count_full = c_count_nbits'(p_max_outs);
  localparam logic [c_ptr_nbits-1:0]   c_ptr_zero   = {c_ptr_nbits{1'b0}};
  localparam logic [c_ptr_nbits-1:0]   c_ptr_one    = c_ptr_nbits'(1);
  localparam logic [p_cnt_nbits-1:0]   c_cnt_zero   = {p_cnt_nbits{1'b0}};
  localparam logic [p_cnt_nbits-1:0]   c_cnt_one    = p_cnt_nbits'(1);
  localparam logic [p_cnt_nbits-1:0]   c_cnt_max    = {p_cnt_nbits{1'b1}};
  localparam logic [p_data_nbits-1:0]  c_data_zero  = {p_data_nbits{1'b0}};
  localparam logic [c_len_nbits-1:0]   c_len_zero   = {c_len_nbits{1'b0}};
  localparam logic [c_resp_nbits-1:0]  c_resp_zero  = {c_resp_nbits{1'b0}};
  localparam logic [p_dom_nbits-1:0]   c_dom_zero   = {p_dom_nbits{1'b0}};

  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic [2:0]                req_type_s;
  logic [p_opaque_nbits-1:0] req_opaque_s;

  assign req_type_s   = bus.net_req_control[c_req_nbits-1 -: 3];
  assign req_opaque_s = bus.net_req_control[c_req_nbits-4 -: p_opaque_nbits];

  // -------------------------------------------------------------------------
  // Outstanding-request FIFO state
  // -------------------------------------------------------------------------
  logic [c_count_nbits-1:0]  count_r;
  logic [c_ptr_nbits-1:0]    wr_ptr_r;
  logic [c_ptr_nbits-1:0]    rd_ptr_r;
  logic [p_cnt_nbits-1:0]    deny_count_r;

  // The response length of a denied entry is always zero, so len is not kept.
  logic [p_dom_nbits-1:0]    ent_domain_r [0:p_max_outs-1];
  logic                      ent_denied_r [0:p_max_outs-1];
  logic [2:0]                ent_type_r   [0:p_max_outs-1];
  logic [p_opaque_nbits-1:0] ent_opaque_r [0:p_max_outs-1];

  logic                      full_s;
  logic                      empty_s;
  logic                      allowed_s;
  logic                      push_s;
  logic                      pop_s;

  logic                      net_req_rdy_s;
  logic                      mem_req_val_s;
  logic [p_data_nbits-1:0]   mem_req_data_s;

  logic                      net_resp_val_s;
  logic [c_resp_nbits-1:0]   net_resp_control_s;
  logic [p_data_nbits-1:0]   net_resp_data_s;
  logic [p_dom_nbits-1:0]    net_resp_domain_s;
  logic                      mem_resp_rdy_s;

  logic [p_dom_nbits-1:0]    head_domain_s;
  logic                      head_denied_s;
  logic [2:0]                head_type_s;
  logic [p_opaque_nbits-1:0] head_opaque_s;

  // A pop in the same cycle never frees a slot for a push (no bypass).
  assign full_s  = (count_r == c_count_full);
  assign empty_s = (count_r == c_count_zero);

  assign head_domain_s = ent_domain_r[rd_ptr_r];
  assign head_denied_s = ent_denied_r[rd_ptr_r];
  assign head_type_s   = ent_type_r[rd_ptr_r];
  assign head_opaque_s = ent_opaque_r[rd_ptr_r];

  // Access policy: ordered domains, no read-up and no write-down.
  always_comb begin
    allowed_s = 1'b0;
    case (req_type_s)
      c_type_read:  allowed_s = (bus.net_req_domain >= mem_sec_level);
      c_type_write: allowed_s = (bus.net_req_domain <= mem_sec_level);
      default:      allowed_s = 1'b0;
    endcase
  end

  // Request path: allowed requests wait on memory, denied ones only on FIFO space.
  always_comb begin
    net_req_rdy_s = 1'b0;
    mem_req_val_s = 1'b0;
    if (allowed_s) begin
      net_req_rdy_s = bus.mem_req_rdy & ~full_s;
      mem_req_val_s = bus.net_req_val & ~full_s;
    end else begin
      net_req_rdy_s = ~full_s;
      mem_req_val_s = 1'b0;
    end
  end

  // Gate write data so nothing from a denied or idle request reaches memory.
  always_comb begin
    mem_req_data_s = c_data_zero;
    if (mem_req_val_s) begin
      mem_req_data_s = bus.net_req_data;
    end else begin
      mem_req_data_s = c_data_zero;
    end
  end

  assign push_s = bus.net_req_val & net_req_rdy_s;

  // Response path: denied heads are answered locally, allowed heads wait on memory.
  always_comb begin
    net_resp_val_s     = 1'b0;
    net_resp_control_s = c_resp_zero;
    net_resp_data_s    = c_data_zero;
    net_resp_domain_s  = c_dom_zero;
    mem_resp_rdy_s     = 1'b0;
    if (empty_s) begin
      // A stray memory response is held off rather than dropped.
      net_resp_val_s = 1'b0;
      mem_resp_rdy_s = 1'b0;
    end else if (head_denied_s) begin
      net_resp_val_s     = 1'b1;
      net_resp_control_s = {head_type_s, head_opaque_s, c_len_zero};
      net_resp_data_s    = c_data_zero;
      net_resp_domain_s  = head_domain_s;
      mem_resp_rdy_s     = 1'b0;
    end else begin
      net_resp_val_s     = bus.mem_resp_val;
      net_resp_control_s = bus.mem_resp_control;
      net_resp_data_s    = bus.mem_resp_data;
      net_resp_domain_s  = head_domain_s;
      mem_resp_rdy_s     = bus.net_resp_rdy;
    end
  end

  assign pop_s = net_resp_val_s & bus.net_resp_rdy;

  // FIFO occupancy and pointers; pointers wrap naturally at p_max_outs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r  <= c_count_zero;
      wr_ptr_r <= c_ptr_zero;
      rd_ptr_r <= c_ptr_zero;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + c_ptr_one;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + c_ptr_one;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + c_count_one;
        2'b01:   count_r <= count_r - c_count_one;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO entry storage; contents are don't-care until written by a push.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ent_domain_r[wr_ptr_r] <= bus.net_req_domain;
      ent_denied_r[wr_ptr_r] <= ~allowed_s;
      ent_type_r[wr_ptr_r]   <= req_type_s;
      ent_opaque_r[wr_ptr_r] <= req_opaque_s;
    end
  end

  // Saturating count of accepted denied requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      deny_count_r <= c_cnt_zero;
    end else if (push_s && !allowed_s && (deny_count_r != c_cnt_max)) begin
      deny_count_r <= deny_count_r + c_cnt_one;
    end else begin
      deny_count_r <= deny_count_r;
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.net_req_rdy      = net_req_rdy_s;
  assign bus.mem_req_val      = mem_req_val_s;
  assign bus.mem_req_control  = bus.net_req_control;
  assign bus.mem_req_data     = mem_req_data_s;
  assign bus.mem_resp_rdy     = mem_resp_rdy_s;
  assign bus.net_resp_val     = net_resp_val_s;
  assign bus.net_resp_control = net_resp_control_s;
  assign bus.net_resp_data    = net_resp_data_s;
  assign bus.net_resp_domain  = net_resp_domain_s;
  assign deny_count           = deny_count_r;

endmodule

// File: tb/tb_plab5_mcore_mem_acc_ndom.sv
// ---------------------------------------------------------------------------
// tb_plab5_mcore_mem_acc_ndom
//
// Self-checking bench: a behavioural memory sits on the memory side, and a
// reference model (policy function, expected-response queue, reference
// memory array, saturating deny counter) predicts every handshake and every
// response on the network side. Inputs change #1 after the rising edge;
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_plab5_mcore_mem_acc_ndom;

  localparam int c_outs = 4;
  localparam int c_cnt_max = 255;

  typedef struct {
    bit [2:0]  typ;
    bit [7:0]  opq;
    bit [31:0] addr;
    bit [1:0]  len;
    bit [31:0] data;
    bit [1:0]  dom;
  } req_t;

  typedef struct {
    bit [1:0]  dom;
    bit        denied;
    bit [12:0] ctrl;
    bit [31:0] data;
  } exp_t;

  typedef struct {
    bit [12:0] ctrl;
    bit [31:0] data;
    int        ready;
  } mresp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mem_sec_level;
  logic [7:0] deny_count;

  always #5 clk = ~clk;

  plab5_mcore_mem_acc_ndom_if #(
    .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32), .p_dom_nbits(2)
  ) bus ();

  plab5_mcore_mem_acc_ndom #(
    .p_opaque_nbits(8), .p_addr_nbits(32), .p_data_nbits(32), .p_dom_nbits(2),
    .p_max_outs(c_outs), .p_cnt_nbits(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_sec_level(mem_sec_level),
    .bus(bus),
    .deny_count(deny_count)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  req_t   stim_q[$];
  exp_t   exp_q[$];
  mresp_t mem_q[$];
  bit [31:0] mem_arr [bit [31:0]];
  bit [31:0] ref_mem [bit [31:0]];
  int ref_deny = 0;

  int mem_lat = 1;
  int mem_rdy_pct = 100;
  int resp_rdy_pct = 100;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Security policy from first principles.
  function automatic bit policy_ok(input bit [2:0] typ, input bit [1:0] dom, input bit [1:0] lvl);
    if (typ == 3'd0) return (dom >= lvl);
    if (typ == 3'd1) return (dom <= lvl);
    return 1'b0;
  endfunction

  task automatic push_req(input bit [2:0] typ, input bit [1:0] dom,
                          input bit [31:0] addr, input bit [31:0] data);
    req_t r;
    r.typ = typ; r.dom = dom; r.addr = addr; r.data = data;
    r.opq = 8'($urandom);
    r.len = 2'($urandom);
    stim_q.push_back(r);
  endtask

  task automatic push_random_req();
    int k;
    bit [2:0] t;
    bit [31:0] a;
    k = $urandom_range(0, 9);
    if (k < 4)      t = 3'd0;
    else if (k < 8) t = 3'd1;
    else            t = 3'($urandom_range(2, 7));
    a = 32'h100 + 32'($urandom_range(0, 3)) * 32'h4;
    push_req(t, 2'($urandom), a, $urandom);
  endtask

  // One clock cycle: sample and check at the falling edge, update models, drive.
  task automatic step();
    req_t   s;
    exp_t   e;
    mresp_t m;
    bit     allowed, full, req_fire, resp_fire;
    bit [2:0]  mt;
    bit [31:0] ma;
    @(negedge clk);
    req_fire = 1'b0;
    resp_fire = 1'b0;
    if (!reset) begin
      full = (exp_q.size() >= c_outs);
      check("deny_count", deny_count, ref_deny);
      if (bus.net_req_val) begin
        s = stim_q[0];
        allowed = policy_ok(s.typ, s.dom, mem_sec_level);
        check("net_req_rdy", bus.net_req_rdy, full ? 1'b0 : (allowed ? bus.mem_req_rdy : 1'b1));
        check("mem_req_val", bus.mem_req_val, allowed && !full);
        if (allowed && !full) begin
          check("mem_req_control", bus.mem_req_control, {s.typ, s.opq, s.addr, s.len});
          check("mem_req_data", bus.mem_req_data, s.data);
        end else begin
          check("mem_req_data_zero", bus.mem_req_data, 32'h0);
        end
        req_fire = bus.net_req_rdy;
      end else begin
        check("mem_req_val_idle", bus.mem_req_val, 1'b0);
        check("mem_req_data_idle", bus.mem_req_data, 32'h0);
      end
      if (exp_q.size() == 0) begin
        check("net_resp_val_empty", bus.net_resp_val, 1'b0);
        check("net_resp_domain_empty", bus.net_resp_domain, 2'd0);
        check("mem_resp_rdy_empty", bus.mem_resp_rdy, 1'b0);
      end else begin
        e = exp_q[0];
        check("net_resp_domain", bus.net_resp_domain, e.dom);
        if (e.denied) begin
          check("net_resp_val_deny", bus.net_resp_val, 1'b1);
          check("mem_resp_rdy_deny", bus.mem_resp_rdy, 1'b0);
        end else begin
          check("net_resp_val_pass", bus.net_resp_val, bus.mem_resp_val);
          check("mem_resp_rdy_pass", bus.mem_resp_rdy, bus.net_resp_rdy);
        end
        if (bus.net_resp_val && bus.net_resp_rdy) begin
          check("net_resp_control", bus.net_resp_control, e.ctrl);
          check("net_resp_data", bus.net_resp_data, e.data);
          resp_fire = 1'b1;
        end
      end
    end
    // Behavioural memory reacts to whatever the DUT actually forwarded.
    if (bus.mem_resp_val && bus.mem_resp_rdy) void'(mem_q.pop_front());
    if (bus.mem_req_val && bus.mem_req_rdy) begin
      mt = bus.mem_req_control[44:42];
      ma = bus.mem_req_control[33:2];
      m.data = 32'h0;
      if (mt == 3'd1) mem_arr[ma] = bus.mem_req_data;
      else if (mt == 3'd0 && mem_arr.exists(ma)) m.data = mem_arr[ma];
      m.ctrl = {mt, bus.mem_req_control[41:34], bus.mem_req_control[1:0]};
      m.ready = cyc + mem_lat;
      mem_q.push_back(m);
    end
    if (resp_fire) void'(exp_q.pop_front());
    if (req_fire) begin
      s = stim_q.pop_front();
      e.dom = s.dom;
      e.denied = !policy_ok(s.typ, s.dom, mem_sec_level);
      e.data = 32'h0;
      if (e.denied) begin
        e.ctrl = {s.typ, s.opq, 2'b00};
        if (ref_deny < c_cnt_max) ref_deny++;
      end else begin
        e.ctrl = {s.typ, s.opq, s.len};
        if (s.typ == 3'd1) ref_mem[s.addr] = s.data;
        else if (ref_mem.exists(s.addr)) e.data = ref_mem[s.addr];
      end
      exp_q.push_back(e);
    end
    if (reset) begin
      exp_q.delete();
      mem_q.delete();
      ref_deny = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_req_rdy  = ($urandom_range(0, 99) < mem_rdy_pct);
    bus.net_resp_rdy = ($urandom_range(0, 99) < resp_rdy_pct);
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      bus.mem_resp_val     = 1'b1;
      bus.mem_resp_control = mem_q[0].ctrl;
      bus.mem_resp_data    = mem_q[0].data;
    end else begin
      bus.mem_resp_val     = 1'b0;
      bus.mem_resp_control = 13'($urandom);
      bus.mem_resp_data    = $urandom;
    end
    if (!reset && stim_q.size() > 0) begin
      s = stim_q[0];
      bus.net_req_val     = 1'b1;
      bus.net_req_control = {s.typ, s.opq, s.addr, s.len};
      bus.net_req_data    = s.data;
      bus.net_req_domain  = s.dom;
    end else begin
      bus.net_req_val     = 1'b0;
      bus.net_req_control = {13'($urandom), 32'($urandom)};
      bus.net_req_data    = $urandom;
      bus.net_req_domain  = 2'($urandom);
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((stim_q.size() + exp_q.size() + mem_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", exp_q.size() + stim_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    mem_sec_level = 2'd1;
    bus.net_req_val = 1'b0;
    bus.net_req_control = '0;
    bus.net_req_data = '0;
    bus.net_req_domain = '0;
    bus.mem_req_rdy = 1'b1;
    bus.mem_resp_val = 1'b0;
    bus.mem_resp_control = '0;
    bus.mem_resp_data = '0;
    bus.net_resp_rdy = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("reset_deny_count", deny_count, 8'd0);
    check("reset_net_resp_val", bus.net_resp_val, 1'b0);

    // Allowed write then read-down: data comes back tagged domain 2.
    push_req(3'd1, 2'd1, 32'h100, 32'hCAFE);
    push_req(3'd0, 2'd2, 32'h100, 32'h0);
    run_idle(50);
    check("deny_after_allowed", deny_count, 8'd0);

    // Read-up denied: answered locally on the next cycle.
    push_req(3'd0, 2'd0, 32'h100, 32'h0);
    run_idle(20);
    check("deny_after_read_up", deny_count, 8'd1);

    // Write-down denied, memory keeps 0xCAFE.
    push_req(3'd1, 2'd3, 32'h100, 32'hBEEF);
    push_req(3'd0, 2'd1, 32'h100, 32'h0);
    run_idle(50);
    check("deny_after_write_down", deny_count, 8'd2);

    // Ordering: slow allowed read then denied read, domains 2 then 0.
    mem_lat = 5;
    push_req(3'd0, 2'd2, 32'h100, 32'h0);
    push_req(3'd0, 2'd0, 32'h104, 32'h0);
    run_idle(60);
    mem_lat = 1;

    // Fill the FIFO with responses blocked; only four may be accepted.
    resp_rdy_pct = 0;
    for (int i = 0; i < 5; i++) push_req(3'(i % 2 == 0 ? 0 : 0), 2'(i % 2 == 0 ? 2 : 0), 32'h100, 32'h0);
    repeat (12) step();
    check("fifo_full_stall", stim_q.size(), 1);
    resp_rdy_pct = 100;
    for (int i = 0; i < 20; i++) push_random_req();
    run_idle(200);

    // Reset with three entries outstanding.
    resp_rdy_pct = 0;
    for (int i = 0; i < 3; i++) push_req(3'd0, 2'd0, 32'h100, 32'h0);
    for (int i = 0; i < 20 && stim_q.size() != 0; i++) step();
    check("pre_reset_outstanding", exp_q.size(), 3);
    reset = 1'b1;
    bus.net_req_val = 1'b0;
    step();
    reset = 1'b0;
    check("post_reset_net_resp_val", bus.net_resp_val, 1'b0);
    check("post_reset_deny_count", deny_count, 8'd0);
    check("post_reset_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
    check("post_reset_domain", bus.net_resp_domain, 2'd0);
    resp_rdy_pct = 100;
    step();

    // Randomised traffic over all bank levels and ready patterns.
    for (int b = 0; b < 8; b++) begin
      mem_sec_level = 2'($urandom);
      mem_lat = $urandom_range(0, 4);
      mem_rdy_pct = $urandom_range(40, 100);
      resp_rdy_pct = $urandom_range(40, 100);
      for (int i = 0; i < 40; i++) push_random_req();
      run_idle(2000);
    end

    // Saturate the deny counter.
    mem_sec_level = 2'd3;
    mem_lat = 1;
    mem_rdy_pct = 100;
    resp_rdy_pct = 100;
    for (int i = 0; i < 300; i++) push_req(3'd0, 2'd0, 32'h100, 32'h0);
    run_idle(3000);
    check("deny_saturated", deny_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
